// File: rtl/rv32i_dmem_pkg.sv
// Shared definitions for the rv32i data-bus responder: MMIO register map,
// FSM and read-select encodings, address decode and byte-merge helpers.
package rv32i_dmem_pkg;

   localparam logic [4:0] MSIP        = 5'h00;
   localparam logic [4:0] MTIMECMP_LO = 5'h08;
   localparam logic [4:0] MTIMECMP_HI = 5'h0C;
   localparam logic [4:0] MTIME_LO    = 5'h10;
   localparam logic [4:0] MTIME_HI    = 5'h14;

   localparam logic [31:0] MMIO_BYTES = 32'd32;

   typedef enum logic {SYNC, RUN} state_t;

   typedef enum logic [1:0] {RD_NONE, RD_RAM, RD_MMIO} rd_sel_t;

   // Unsigned offset compare, so regions may sit anywhere in the address space.
   function automatic logic in_region(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] size);
      return (addr - base) < size;
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] data,
                                               input logic [3:0]  mask);
      logic [31:0] r;
      r = old_word;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) r[i*8 +: 8] = data[i*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/rv32i_bram.sv
// Word-wide synchronous RAM with per-byte write enables and a registered
// read port that returns the pre-write contents on a same-address access.
module rv32i_bram #(
   parameter int unsigned WORDS = 1024
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [3:0]                 be,
   input  logic [$clog2(WORDS)-1:0]   addr,
   input  logic [31:0]                wdata,
   output logic [31:0]                rdata
);

   logic [31:0] mem [WORDS];

   always_ff @(posedge clk) begin
      rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
         if (we && be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
   end

endmodule

// File: rtl/rv32i_dmem_responder.sv
// Data-bus target for the rv32i core: word RAM plus msip/mtimecmp/mtime
// registers, pushing timer shadows to the core on writes and after reset.
module rv32i_dmem_responder
   import rv32i_dmem_pkg::*;
#(
   parameter int unsigned RAM_WORDS    = 1024,
   parameter logic [31:0] RAM_BASE     = 32'h0000_0000,
   parameter logic [31:0] MMIO_BASE    = 32'h8000_0000,
   parameter int unsigned CLK_FREQ_MHZ = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] daddr,
   input  logic [31:0] dout,
   input  logic [3:0]  wr_mask,
   input  logic        wr_en,
   output logic [31:0] din,
   output logic        software_interrupt,
   output logic        mtime_wr,
   output logic [63:0] mtime_din,
   output logic        mtimecmp_wr,
   output logic [63:0] mtimecmp_din
);

   localparam int unsigned AW = $clog2(RAM_WORDS);
   localparam int unsigned PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ_MHZ - 1);
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

   state_t        state_reg;
   rd_sel_t       rd_sel_reg;
   logic [31:0]   mmio_q_reg;
   logic          msip_reg, msip_next;
   logic [63:0]   cmp_reg, cmp_next;
   logic [63:0]   time_reg, time_next;
   logic [PW-1:0] presc_reg, presc_next;
   logic          cmp_written, time_written, tick;

   logic          ram_hit, mmio_hit, ram_we, mmio_we;
   logic [AW-1:0] ram_idx;
   logic [4:0]    reg_off;
   logic [31:0]   ram_q, mmio_rdata;

   assign ram_hit  = in_region(daddr, RAM_BASE, RAM_BYTES);
   assign mmio_hit = in_region(daddr, MMIO_BASE, MMIO_BYTES);
   assign ram_idx  = AW'((daddr - RAM_BASE) >> 2);
   assign reg_off  = 5'(daddr - MMIO_BASE) & 5'h1C;
   assign ram_we   = wr_en && ram_hit;
   assign mmio_we  = wr_en && mmio_hit && (wr_mask != 4'b0000);

   rv32i_bram #(.WORDS(RAM_WORDS)) u_bram (
      .clk   (clk),
      .we    (ram_we),
      .be    (wr_mask),
      .addr  (ram_idx),
      .wdata (dout),
      .rdata (ram_q)
   );

   always_comb begin
      case (reg_off)
         MSIP:        mmio_rdata = {31'b0, msip_reg};
         MTIMECMP_LO: mmio_rdata = cmp_reg[31:0];
         MTIMECMP_HI: mmio_rdata = cmp_reg[63:32];
         MTIME_LO:    mmio_rdata = time_reg[31:0];
         MTIME_HI:    mmio_rdata = time_reg[63:32];
         default:     mmio_rdata = '0;
      endcase
   end

   // A write to either mtime half overrides the tick; the prescaler is
   // already wrapping to 0 on that cycle, so the clear comes for free.
   always_comb begin
      msip_next    = msip_reg;
      cmp_next     = cmp_reg;
      time_next    = time_reg;
      presc_next   = presc_reg + PW'(1);
      cmp_written  = 1'b0;
      time_written = 1'b0;
      tick         = (presc_reg == PRESC_MAX);
      if (tick) begin
         presc_next = '0;
         time_next  = time_reg + 64'd1;
      end
      if (mmio_we) begin
         case (reg_off)
            MSIP: begin
               if (wr_mask[0]) msip_next = dout[0];
            end
            MTIMECMP_LO: begin
               cmp_next    = {cmp_reg[63:32], merge_bytes(cmp_reg[31:0], dout, wr_mask)};
               cmp_written = 1'b1;
            end
            MTIMECMP_HI: begin
               cmp_next    = {merge_bytes(cmp_reg[63:32], dout, wr_mask), cmp_reg[31:0]};
               cmp_written = 1'b1;
            end
            MTIME_LO: begin
               time_next    = {time_reg[63:32], merge_bytes(time_reg[31:0], dout, wr_mask)};
               time_written = 1'b1;
            end
            MTIME_HI: begin
               time_next    = {merge_bytes(time_reg[63:32], dout, wr_mask), time_reg[31:0]};
               time_written = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= SYNC;
         rd_sel_reg   <= RD_NONE;
         mmio_q_reg   <= '0;
         msip_reg     <= 1'b0;
         cmp_reg      <= '1;
         time_reg     <= '0;
         presc_reg    <= '0;
         mtime_wr     <= 1'b0;
         mtime_din    <= '0;
         mtimecmp_wr  <= 1'b0;
         mtimecmp_din <= '0;
      end else begin
         state_reg  <= RUN;
         rd_sel_reg <= ram_hit ? RD_RAM : (mmio_hit ? RD_MMIO : RD_NONE);
         mmio_q_reg <= mmio_rdata;
         msip_reg   <= msip_next;
         cmp_reg    <= cmp_next;
         time_reg   <= time_next;
         presc_reg  <= presc_next;
         // SYNC pushes both shadows once so the core starts from the reset state.
         mtime_wr    <= (state_reg == SYNC) || time_written;
         mtimecmp_wr <= (state_reg == SYNC) || cmp_written;
         if ((state_reg == SYNC) || time_written) mtime_din    <= time_next;
         if ((state_reg == SYNC) || cmp_written)  mtimecmp_din <= cmp_next;
      end
   end

   assign software_interrupt = msip_reg;

   always_comb begin
      case (rd_sel_reg)
         RD_RAM:  din = ram_q;
         RD_MMIO: din = mmio_q_reg;
         default: din = '0;
      endcase
   end

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Directed bench for rv32i_dmem_responder: reset sync pulses, RAM byte lanes,
// timer shadow writes and ticks, msip, unmapped accesses and mid-run reset.
module tb_rv32i_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] daddr, dout;
   logic [3:0]  wr_mask;
   logic        wr_en;
   logic [31:0] din;
   logic        software_interrupt, mtime_wr, mtimecmp_wr;
   logic [63:0] mtime_din, mtimecmp_din;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rv32i_dmem_responder #(
      .RAM_WORDS    (1024),
      .RAM_BASE     (32'h0000_0000),
      .MMIO_BASE    (32'h8000_0000),
      .CLK_FREQ_MHZ (4)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .daddr              (daddr),
      .dout               (dout),
      .wr_mask            (wr_mask),
      .wr_en              (wr_en),
      .din                (din),
      .software_interrupt (software_interrupt),
      .mtime_wr           (mtime_wr),
      .mtime_din          (mtime_din),
      .mtimecmp_wr        (mtimecmp_wr),
      .mtimecmp_din       (mtimecmp_din)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      wr_en   = we;
      daddr   = a;
      dout    = d;
      wr_mask = m;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 32'h4000_0000, 32'h0, 4'h0);
      step();
      step();
      check("rst_din", 64'(din), 64'h0);
      check("rst_si", 64'(software_interrupt), 64'h0);
      check("rst_mtime_wr", 64'(mtime_wr), 64'h0);
      check("rst_mtimecmp_wr", 64'(mtimecmp_wr), 64'h0);
      check("rst_mtime_din", mtime_din, 64'h0);
      check("rst_mtimecmp_din", mtimecmp_din, 64'h0);

      // Reset release: one SYNC pulse pair on the first edge, nothing after.
      rst = 1'b0;
      step();  // E1
      check("sync_mtime_wr", 64'(mtime_wr), 64'h1);
      check("sync_mtime_din", mtime_din, 64'h0);
      check("sync_mtimecmp_wr", 64'(mtimecmp_wr), 64'h1);
      check("sync_mtimecmp_din", mtimecmp_din, 64'hFFFF_FFFF_FFFF_FFFF);
      step();  // E2
      check("post_sync_mtime_wr", 64'(mtime_wr), 64'h0);
      check("post_sync_mtimecmp_wr", 64'(mtimecmp_wr), 64'h0);

      // Prescale 4: ticks land on edges E4, E8, E12, E16, E20 ...
      drive(1'b0, 32'h8000_0010, 32'h0, 4'h0);
      repeat (11) step();  // E13
      check("mtime_lo_after_12", 64'(din), 64'h3);
      step();
      step();  // E15
      drive(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'hF);
      step();  // E16: write collides with tick
      check("collide_mtime_wr", 64'(mtime_wr), 64'h1);
      check("collide_mtime_din", mtime_din, 64'h0000_0000_FFFF_FFFF);
      drive(1'b0, 32'h8000_0010, 32'h0, 4'h0);
      step();  // E17
      check("collide_no_incr", 64'(din), 64'hFFFF_FFFF);
      check("tick_no_pulse", 64'(mtime_wr), 64'h0);
      drive(1'b0, 32'h8000_0014, 32'h0, 4'h0);
      repeat (3) step();  // E20: captures hi before the carry
      check("mtime_hi_pre_carry", 64'(din), 64'h0);
      step();  // E21
      check("mtime_hi_carry", 64'(din), 64'h1);
      drive(1'b0, 32'h8000_0010, 32'h0, 4'h0);
      step();
      check("mtime_lo_carry", 64'(din), 64'h0);

      // RAM byte lanes and read-before-write.
      drive(1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'b1111);
      step();
      drive(1'b1, 32'h0000_0010, 32'h0000_1100, 4'b0010);
      step();
      check("ram_rbw_old", 64'(din), 64'hAABB_CCDD);
      drive(1'b1, 32'h0000_0010, 32'h0, 4'b0000);
      step();
      check("ram_merged", 64'(din), 64'hAABB_11DD);
      drive(1'b0, 32'h0000_0013, 32'h0, 4'h0);
      step();
      check("ram_mask0_noop", 64'(din), 64'hAABB_11DD);

      // mtimecmp split write.
      drive(1'b1, 32'h8000_0008, 32'h0000_1000, 4'hF);
      step();
      check("cmp_lo_wr", 64'(mtimecmp_wr), 64'h1);
      check("cmp_lo_din", mtimecmp_din, 64'hFFFF_FFFF_0000_1000);
      drive(1'b1, 32'h8000_000C, 32'h0000_0001, 4'hF);
      step();
      check("cmp_hi_wr", 64'(mtimecmp_wr), 64'h1);
      check("cmp_hi_din", mtimecmp_din, 64'h0000_0001_0000_1000);
      drive(1'b0, 32'h8000_000C, 32'h0, 4'h0);
      step();
      check("cmp_pulse_end", 64'(mtimecmp_wr), 64'h0);
      check("cmp_din_hold", mtimecmp_din, 64'h0000_0001_0000_1000);
      check("cmp_hi_read", 64'(din), 64'h1);

      // msip.
      drive(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF);
      step();
      check("msip_set", 64'(software_interrupt), 64'h1);
      drive(1'b0, 32'h8000_0000, 32'h0, 4'h0);
      step();
      check("msip_read", 64'(din), 64'h1);
      drive(1'b1, 32'h8000_0004, 32'h0, 4'hF);
      step();
      check("msip_0x04_keep", 64'(software_interrupt), 64'h1);
      drive(1'b1, 32'h8000_0000, 32'h0, 4'hF);
      step();
      check("msip_clear", 64'(software_interrupt), 64'h0);

      // Unmapped accesses.
      drive(1'b1, 32'h4000_0000, 32'h1234_5678, 4'hF);
      step();
      check("unmap_no_mtime_wr", 64'(mtime_wr), 64'h0);
      check("unmap_no_cmp_wr", 64'(mtimecmp_wr), 64'h0);
      drive(1'b0, 32'h4000_0000, 32'h0, 4'h0);
      step();
      check("unmap_read", 64'(din), 64'h0);
      drive(1'b0, 32'h8000_0018, 32'h0, 4'h0);
      step();
      check("mmio_hole_read", 64'(din), 64'h0);
      drive(1'b0, 32'h0000_0010, 32'h0, 4'h0);
      step();
      check("ram_after_unmap", 64'(din), 64'hAABB_11DD);

      // Mid-run reset with a store in flight: pulse must be cut.
      drive(1'b1, 32'h8000_0000, 32'h1, 4'hF);
      step();
      check("msip_set_again", 64'(software_interrupt), 64'h1);
      rst = 1'b1;
      drive(1'b1, 32'h8000_0008, 32'h0000_0055, 4'hF);
      step();
      check("midrst_si", 64'(software_interrupt), 64'h0);
      check("midrst_din", 64'(din), 64'h0);
      check("midrst_cmp_wr_cut", 64'(mtimecmp_wr), 64'h0);
      check("midrst_mtime_din", mtime_din, 64'h0);
      check("midrst_cmp_din", mtimecmp_din, 64'h0);
      rst = 1'b0;
      drive(1'b0, 32'h8000_0008, 32'h0, 4'h0);
      step();
      check("resync_mtime_wr", 64'(mtime_wr), 64'h1);
      check("resync_mtime_din", mtime_din, 64'h0);
      check("resync_cmp_wr", 64'(mtimecmp_wr), 64'h1);
      check("resync_cmp_din", mtimecmp_din, 64'hFFFF_FFFF_FFFF_FFFF);
      check("resync_cmp_lo_read", 64'(din), 64'hFFFF_FFFF);
      step();
      check("resync_pulse_end", 64'({mtime_wr, mtimecmp_wr}), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
